// File: rtl/piano_pkg.sv
// Shared constants and types for the piano tone path.
//   NUM_NOTES     number of key/voice channels
//   NOTE_CNT_W    width of a half-period count in clk cycles
//   MIX_W         width of a mix level able to hold NUM_NOTES
//   CLK_HZ        board clock frequency
//   note_period_t half-period count type (0 = key released)
//   voice_state_t per-voice FSM state
package piano_pkg;

    localparam int NUM_NOTES  = 13;
    localparam int NOTE_CNT_W = 32;
    localparam int MIX_W      = $clog2(NUM_NOTES + 1);
    localparam int CLK_HZ     = 50_000_000;

    typedef logic [NOTE_CNT_W-1:0] note_period_t;

    typedef enum logic {SILENT, RUN} voice_state_t;

endpackage

// File: rtl/tone_voice.sv
// One square-wave channel: samples its half-period every edge, restarts
// phase (low, count 0) whenever a new value is seen, and toggles its output
// every note_period cycles while running and enabled.
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   note_period  half-period in clk cycles; 0 = silent
//   enable       global mute; 0 forces the voice low on the next edge
//   voice_out    square wave output
module tone_voice #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] note_period,
    input  logic             enable,
    output logic             voice_out
);
    import piano_pkg::*;

    voice_state_t     state;
    voice_state_t     state_next;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] cnt;
    logic             change;
    logic             run_en;
    logic             wrap;

    assign change = (note_period != period_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SILENT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            SILENT:  if (enable && (note_period != '0)) state_next = RUN;
            RUN:     if (!enable || (note_period == '0)) state_next = SILENT;
            default: state_next = SILENT;
        endcase
    end

    // A restart (new period sampled) overrides any toggle due on the same edge.
    always_comb begin
        run_en = (state == RUN) && enable && !change;
        // >= keeps a count left over from a longer period from running past the new limit.
        wrap   = (cnt >= (period_reg - CNT_W'(1)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_reg <= '0;
            cnt        <= '0;
            voice_out  <= 1'b0;
        end else begin
            period_reg <= note_period;
            if (!run_en) begin
                cnt       <= '0;
                voice_out <= 1'b0;
            end else if (wrap) begin
                cnt       <= '0;
                voice_out <= ~voice_out;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tone_synth.sv
// Polyphonic square-wave synthesiser: one tone_voice per key, a registered
// popcount mixer and a registered single-bit speaker drive.
// Optional macro PWM_MIX_EN: when defined the speaker is a PWM of the mix
// level over a frame of NUM_VOICES cycles; otherwise it is the OR of voices.
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   noteFrequency  per-voice half-period in clk cycles; 0 = silent
//   enable         global mute; 0 silences all voices
//   voiceOut       per-voice square waves
//   mixLevel       registered count of voices currently high
//   speaker        single-bit audio drive
module tone_synth #(
    parameter int NUM_VOICES = 13,
    parameter int CNT_W      = 32,
    parameter int MIX_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CNT_W-1:0]      noteFrequency [NUM_VOICES],
    input  logic                  enable,
    output logic [NUM_VOICES-1:0] voiceOut,
    output logic [MIX_W-1:0]      mixLevel,
    output logic                  speaker
);
    import piano_pkg::*;

    logic [MIX_W-1:0] pop_count;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        tone_voice #(
            .CNT_W (CNT_W)
        ) u_voice (
            .clk         (clk),
            .reset_n     (reset_n),
            .note_period (noteFrequency[g]),
            .enable      (enable),
            .voice_out   (voiceOut[g])
        );
    end

    always_comb begin
        pop_count = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            pop_count = pop_count + MIX_W'(voiceOut[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mixLevel <= '0;
        end else begin
            mixLevel <= pop_count;
        end
    end

`ifdef PWM_MIX_EN
    logic [MIX_W-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            speaker <= 1'b0;
        end else begin
            pwm_cnt <= (pwm_cnt == MIX_W'(NUM_VOICES - 1)) ? '0 : pwm_cnt + MIX_W'(1);
            speaker <= (pwm_cnt < mixLevel);
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            speaker <= 1'b0;
        end else begin
            speaker <= (mixLevel != '0);
        end
    end
`endif

endmodule

// File: tb/tb_tone_synth.sv
module tb_tone_synth;
    localparam int NV = 13;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b1;
    logic [31:0]   nf [NV];
    logic [NV-1:0] vo;
    logic [3:0]    ml;
    logic          spk;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tone_synth #(
        .NUM_VOICES (NV),
        .CNT_W      (32),
        .MIX_W      (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .noteFrequency (nf),
        .enable        (enable),
        .voiceOut      (vo),
        .mixLevel      (ml),
        .speaker       (spk)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    // Model: a running voice started (or restarted) at edge s outputs
    // floor((n - s) / P) mod 2 at edge n; mix and speaker lag by one edge each.
    int unsigned   n;
    logic [31:0]   m_prev [NV];
    logic          m_prev_en;
    int unsigned   m_s [NV];
    logic [NV-1:0] m_vo;
    int            m_ml;
    logic          m_spk;

    initial begin
        int pwm_old;
        n = 0; m_vo = '0; m_ml = 0; m_spk = 1'b0; m_prev_en = 1'b0;
        for (int i = 0; i < NV; i++) begin m_prev[i] = '0; m_s[i] = 0; end
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                n = 0; m_vo = '0; m_ml = 0; m_spk = 1'b0; m_prev_en = 1'b0;
                for (int i = 0; i < NV; i++) m_prev[i] = '0;
            end else begin
                n++;
                pwm_old = int'((n - 1) % NV);
`ifdef PWM_MIX_EN
                m_spk = (pwm_old < m_ml);
`else
                m_spk = (m_ml != 0);
`endif
                m_ml = $countones(m_vo);
                for (int i = 0; i < NV; i++) begin
                    if ((nf[i] != m_prev[i]) || (enable && !m_prev_en)) m_s[i] = n;
                    if (enable && (nf[i] != 0))
                        m_vo[i] = (((n - m_s[i]) / nf[i]) % 2) == 1;
                    else
                        m_vo[i] = 1'b0;
                    m_prev[i] = nf[i];
                end
                m_prev_en = enable;
            end
        end
    end

    // Compare against the model after every edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("voiceOut", 32'(vo), 32'(m_vo));
            chk("mixLevel", 32'(ml), 32'(m_ml));
            chk("speaker", 32'(spk), 32'(m_spk));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hi;
        for (int i = 0; i < NV; i++) nf[i] = '0;
        #3;
        chk("rst_vo", 32'(vo), 0);
        chk("rst_ml", 32'(ml), 0);
        chk("rst_spk", 32'(spk), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step(3);

        // Single voice P=4.
        @(negedge clk); nf[0] = 4;
        step(1);                                  // E0
        step(3); chk("v0_e3", 32'(vo[0]), 0);
        step(1); chk("v0_e4", 32'(vo[0]), 1);
        step(1); chk("ml_e5", 32'(ml), 1);
        step(2); chk("v0_e7", 32'(vo[0]), 1);
        step(1); chk("v0_e8", 32'(vo[0]), 0);
        chk("others0", 32'(vo[NV-1:1]), 0);
        @(negedge clk); nf[0] = 0;
        step(3);

        // Minimum period then key release.
        @(negedge clk); nf[3] = 1;
        step(1); chk("p1_e0", 32'(vo[3]), 0);
        step(1); chk("p1_e1", 32'(vo[3]), 1);
        step(1); chk("p1_e2", 32'(vo[3]), 0);
        step(1); chk("p1_e3", 32'(vo[3]), 1);
        @(negedge clk); nf[3] = 0;
        step(1); chk("p1_rel", 32'(vo[3]), 0);
        step(3); chk("p1_rel3", 32'(vo[3]), 0);

        // Retune 6 -> 3 during the high phase.
        @(negedge clk); nf[2] = 6;
        step(1);
        step(7); chk("rt_hi", 32'(vo[2]), 1);
        @(negedge clk); nf[2] = 3;
        step(1); chk("rt_e0", 32'(vo[2]), 0);
        step(2); chk("rt_e2", 32'(vo[2]), 0);
        step(1); chk("rt_e3", 32'(vo[2]), 1);
        step(2); chk("rt_e5", 32'(vo[2]), 1);
        step(1); chk("rt_e6", 32'(vo[2]), 0);
        @(negedge clk); nf[2] = 0;
        step(3);

        // Reset asserted mid-note.
        @(negedge clk); for (int i = 0; i < 4; i++) nf[i] = 5;
        step(7);
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        chk("mr_vo", 32'(vo), 0);
        chk("mr_ml", 32'(ml), 0);
        chk("mr_spk", 32'(spk), 0);
        step(3);
        @(negedge clk); reset_n = 1'b1;
        step(1); chk("mr_e0", 32'(vo), 0);
        step(4); chk("mr_e4", 32'(vo), 0);
        step(1); chk("mr_e5", 32'(vo), 32'h0000_000f);
        @(negedge clk); for (int i = 0; i < 4; i++) nf[i] = 0;
        step(3);

        // Full chord and mute.
        @(negedge clk); for (int i = 0; i < NV; i++) nf[i] = 1000;
        step(1);
        step(1000); chk("ch_vo", 32'(vo), 32'h0000_1fff);
        step(1);    chk("ch_ml", 32'(ml), 13);
        @(negedge clk); enable = 1'b0;
        step(1); chk("mu_vo", 32'(vo), 0);
                 chk("mu_ml_hold", 32'(ml), 13);
        step(1); chk("mu_ml", 32'(ml), 0);
        @(negedge clk); for (int i = 0; i < NV; i++) nf[i] = 0;
        enable = 1'b1;
        step(3);

        // Speaker with 5 voices high.
        @(negedge clk); for (int i = 0; i < 5; i++) nf[i] = 1000;
        step(1);
        step(1002); chk("sp_ml", 32'(ml), 5);
        hi = 0;
        for (int k = 0; k < 2 * NV; k++) begin
            step(1);
            if (spk) hi++;
        end
`ifdef PWM_MIX_EN
        chk("sp_duty", 32'(hi), 10);
`else
        chk("sp_duty", 32'(hi), 26);
`endif
        @(negedge clk); for (int i = 0; i < 5; i++) nf[i] = 0;
        step(1); chk("sp_vo0", 32'(vo), 0);
`ifndef PWM_MIX_EN
        step(1); chk("sp_hold", 32'(spk), 1);
        step(1); chk("sp_off", 32'(spk), 0);
`endif
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
